mem_port_arbiter: RTL and testbench

- Shares one single-port, fixed-latency unified memory between the instruction-fetch requester and the data (load/store) requester of the RV64I core.
- Sits between the core's fetch/MEM stages and the unified memory, replacing the separate instruction and data arrays.
- Allows one outstanding transaction at a time.
- Data requests normally win arbitration; fetch is protected against starvation.

---
 rtl/core_pkg.sv | 11 +
 rtl/arb_prio_sel.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and default widths for the unified-memory port arbiter.
// Pure declarations; no logic, latency or flow control lives here.
package core_pkg;

  localparam int CORE_ADDR_W = 64;
  localparam int CORE_DATA_W = 64;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} arb_state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_e;

endpackage

// File: rtl/arb_prio_sel.sv
// Fetch/data priority pick with anti-starvation counter; selection is combinational (0 cycles).
// Selects nothing unless gnt_en is high; a losing request simply stays pending upstream.
module arb_prio_sel #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_req,
  input  logic gnt_en,
  output logic sel_if,
  output logic sel_d
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == SMAX);

  // A saturated counter only flips priority while fetch is actually asking.
  assign sel_if = gnt_en & if_req & (~d_req | starved);
  assign sel_d  = gnt_en & d_req & ~sel_if;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (sel_if) begin
      starve_cnt <= '0;
    end else if (sel_d) begin
      if (!if_req)
        starve_cnt <= '0;
      else if (!starved)
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between fetch and data requesters, one transaction in flight.
// Grant is same-cycle from req; rvalid follows MEM_LAT cycles later; requesters hold req until gnt.
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W     = CORE_ADDR_W,
  parameter int DATA_W     = CORE_DATA_W,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CW = $clog2(MEM_LAT + 1);

  arb_state_e    state;
  owner_e        owner;
  logic          own_we;
  logic [CW-1:0] cnt;
  logic          gnt_en;
  logic          sel_if;
  logic          sel_d;
  logic          rsp;

  // Gating with rst keeps every output at 0 while reset is held, even with requests pending.
  assign gnt_en = rst & (state == IDLE);

  arb_prio_sel #(
    .STARVE_MAX(STARVE_MAX)
  ) u_sel (
    .clk   (clk),
    .rst   (rst),
    .if_req(if_req),
    .d_req (d_req),
    .gnt_en(gnt_en),
    .sel_if(sel_if),
    .sel_d (sel_d)
  );

  assign if_gnt = sel_if;
  assign d_gnt  = sel_d;

  assign rsp       = (state == WAIT) & (cnt == CW'(1));
  assign if_rvalid = rsp & (owner == OWN_IF);
  assign d_rvalid  = rsp & (owner == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = (d_rvalid && !own_we) ? mem_rdata : '0;

  always_comb begin
    mem_en    = sel_if | sel_d;
    mem_we    = sel_d & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (sel_d) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_wstrb = d_wstrb;
    end else if (sel_if) begin
      mem_addr = if_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      owner  <= OWN_IF;
      own_we <= 1'b0;
    end else if (state == IDLE) begin
      if (sel_if || sel_d) begin
        state  <= WAIT;
        cnt    <= CW'(MEM_LAT);
        owner  <= sel_d ? OWN_D : OWN_IF;
        own_we <= sel_d & d_we;
      end
    end else begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1))
        state <= IDLE;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus random stimulus against a cycle model of the arbiter with a response scoreboard.
module tb_mem_port_arbiter;

  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [7:0]    d_wstrb;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [7:0]    mem_wstrb;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit            is_if;
    int            due;
    logic [63:0]   data;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  glog[$];
  int          gcyc[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          busy = 0;
  int          starve = 0;
  int          frc_cyc = -1;
  logic [63:0] frc_val = '0;
  int          last_drv = -1;
  bit          hold = 0;
  bit          rnd = 0;
  logic        o_if_gnt, o_d_gnt, o_if_rv, o_d_rv, o_mem_we;
  logic [63:0] o_if_rd, o_d_rd, o_addr;
  logic [7:0]  o_wstrb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pattern(input int c);
    if (c == frc_cyc) return frc_val;
    return {32'hC0DE_0000 ^ 32'(c), 32'h9E37_79B9 * 32'(c)};
  endfunction

  task automatic check();
    logic        e_if, e_d, e_ifv, e_dv;
    logic [63:0] e_ifd, e_dd;
    exp_t        e;
    if (!rst) begin
      busy = 0;
      starve = 0;
      sbq.delete();
    end
    e_if = 1'b0;
    e_d  = 1'b0;
    if (rst && busy == 0) begin
      if (if_req && (!d_req || starve == SMAX)) e_if = 1'b1;
      else if (d_req) e_d = 1'b1;
    end
    chk("if_gnt", if_gnt, e_if);
    chk("d_gnt", d_gnt, e_d);
    chk("mem_en", mem_en, e_if | e_d);
    chk("mem_we", mem_we, e_d & d_we);
    chk("mem_addr", mem_addr, e_d ? d_addr : (e_if ? if_addr : 64'd0));
    chk("mem_wdata", mem_wdata, e_d ? d_wdata : 64'd0);
    chk("mem_wstrb", {56'd0, mem_wstrb}, e_d ? {56'd0, d_wstrb} : 64'd0);

    e_ifv = 1'b0; e_dv = 1'b0; e_ifd = '0; e_dd = '0;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      if (sbq[0].is_if) begin e_ifv = 1'b1; e_ifd = sbq[0].data; end
      else begin e_dv = 1'b1; e_dd = sbq[0].data; end
      void'(sbq.pop_front());
    end
    chk("if_rvalid", if_rvalid, e_ifv);
    chk("if_rdata", if_rdata, e_ifd);
    chk("d_rvalid", d_rvalid, e_dv);
    chk("d_rdata", d_rdata, e_dd);

    if (e_if || e_d) begin
      e.is_if = e_if;
      e.due   = cyc + LAT;
      e.data  = (e_d && d_we) ? 64'd0 : pattern(cyc + LAT);
      sbq.push_back(e);
      busy = LAT;
    end else if (busy > 0) begin
      busy--;
    end
    if (e_if) starve = 0;
    else if (e_d) starve = if_req ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;

    if (if_gnt) begin glog.push_back("F"); gcyc.push_back(cyc); end
    if (d_gnt)  begin glog.push_back("D"); gcyc.push_back(cyc); end
    if (d_rvalid) last_drv = cyc;
    o_if_gnt = if_gnt; o_d_gnt = d_gnt; o_if_rv = if_rvalid; o_d_rv = d_rvalid;
    o_if_rd = if_rdata; o_d_rd = d_rdata; o_addr = mem_addr;
    o_mem_we = mem_we; o_wstrb = mem_wstrb;
  endtask

  task automatic rnd_drive();
    if (!if_req && $urandom_range(3) == 0) begin
      if_req = 1'b1;
      if_addr = {$urandom, $urandom};
    end else if (if_req && $urandom_range(7) == 0) begin
      if_req = 1'b0;
    end
    if (!d_req && $urandom_range(2) == 0) begin
      d_req = 1'b1;
      d_we = 1'($urandom_range(1));
      d_addr = {$urandom, $urandom};
      d_wdata = {$urandom, $urandom};
      d_wstrb = 8'($urandom);
    end else if (d_req && $urandom_range(7) == 0) begin
      d_req = 1'b0;
    end
  endtask

  // One clock: drive memory data, sample at negedge, then act as requesters after posedge.
  task automatic step();
    mem_rdata = pattern(cyc);
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
    cyc++;
    if (!hold) begin
      if (o_if_gnt) if_req = 1'b0;
      if (o_d_gnt) d_req = 1'b0;
    end
    if (rnd) rnd_drive();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    int    t;
    string exp_ord;
    exp_ord = "DDDDFDDDDF";
    rst = 1'b0; if_req = 1'b1; d_req = 1'b1;
    if_addr = 64'h40; d_addr = 64'h80; d_we = 1'b0;
    d_wdata = '0; d_wstrb = '0; mem_rdata = '0;
    @(posedge clk);
    #1;

    hold = 1;
    idle(3);
    hold = 0;
    rst = 1'b1;
    glog.delete(); gcyc.delete();
    step();
    chk("first_gnt_after_rst", o_d_gnt, 1'b1);
    idle(4);
    chk("post_rst_second_is_f", {56'd0, glog[1]}, 64'h46);
    idle(3);

    if_req = 1'b1; if_addr = 64'h1c;
    frc_cyc = cyc + 2; frc_val = 64'h13;
    step();
    chk("fetch_gnt", o_if_gnt, 1'b1);
    chk("fetch_addr", o_addr, 64'h1c);
    idle(2);
    chk("fetch_rvalid", o_if_rv, 1'b1);
    chk("fetch_rdata", o_if_rd, 64'h13);
    idle(2);

    glog.delete(); gcyc.delete();
    t = cyc;
    if_req = 1'b1; if_addr = 64'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100;
    idle(6);
    chk("collide_first_d", {56'd0, glog[0]}, 64'h44);
    chk("collide_d_cyc", gcyc[0], t);
    chk("collide_d_rvalid_cyc", last_drv, t + 2);
    chk("collide_second_f", {56'd0, glog[1]}, 64'h46);
    chk("collide_f_cyc", gcyc[1], t + 3);

    glog.delete(); gcyc.delete();
    hold = 1;
    if_req = 1'b1; d_req = 1'b1; d_addr = 64'h180;
    idle(30);
    hold = 0;
    if_req = 1'b0; d_req = 1'b0;
    for (int i = 0; i < 10; i++)
      chk("starve_order", {56'd0, glog[i]}, {56'd0, exp_ord[i]});
    for (int i = 1; i < 10; i++)
      chk("starve_spacing", gcyc[i] - gcyc[i-1], 3);
    idle(3);

    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h200;
    d_wdata = 64'hDEAD_BEEF; d_wstrb = 8'h0F;
    step();
    chk("store_mem_we", o_mem_we, 1'b1);
    chk("store_wstrb", {56'd0, o_wstrb}, 64'h0F);
    idle(2);
    chk("store_rvalid", o_d_rv, 1'b1);
    chk("store_rdata", o_d_rd, 64'h0);
    d_we = 1'b0;
    idle(2);

    d_req = 1'b1; d_addr = 64'h300;
    step();
    chk("midrst_gnt", o_d_gnt, 1'b1);
    rst = 1'b0; if_req = 1'b1; if_addr = 64'h44;
    idle(2);
    chk("midrst_no_rvalid", o_d_rv, 1'b0);
    rst = 1'b1;
    step();
    chk("midrst_if_gnt", o_if_gnt, 1'b1);
    idle(4);

    rnd = 1;
    idle(300);
    rnd = 0;
    if_req = 1'b0; d_req = 1'b0;
    idle(5);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
